// File: rtl/ship_input_sequencer.sv
// Player button front end: synchronise and debounce the buttons, pace ship moves per frame,
// and run the single-shot fire handshake with the laser block.
module ship_input_sequencer #(
    parameter int unsigned DEBOUNCE_FRAMES      = 2,
    parameter int unsigned MOVE_PERIOD_FRAMES   = 3,
    parameter int unsigned FIRE_COOLDOWN_FRAMES = 20,
    parameter int unsigned CNT_W                = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic frameTick,
    input  logic btnLeft,
    input  logic btnRight,
    input  logic btnFire,
    input  logic laserBusy,
    input  logic fireAck,
    output logic moveLeft,
    output logic moveRight,
    output logic fireReq
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [CNT_W-1:0] MV_RELOAD = CNT_W'(MOVE_PERIOD_FRAMES - 1);
    localparam logic [CNT_W-1:0] CD_LOAD   = CNT_W'(FIRE_COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FLIGHT,
        S_COOL
    } state_t;

    // bit 0 = left, bit 1 = right, bit 2 = fire
    logic [2:0]       sync_a;
    logic [2:0]       sync_b;
    logic [2:0]       db;
    logic [CNT_W-1:0] dc [3];
    logic [CNT_W-1:0] mcnt;
    logic [CNT_W-1:0] ccnt;
    logic [CNT_W-1:0] ccnt_next;
    logic             armed;
    state_t           state;
    state_t           state_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {btnFire, btnRight, btnLeft};
            sync_b <= sync_a;
        end
    end

    // dc == DEBOUNCE_FRAMES-1 is the non-overflowing form of dc+1 == DEBOUNCE_FRAMES
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db <= '0;
            for (int unsigned i = 0; i < 3; i++) dc[i] <= '0;
        end else if (frameTick) begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync_b[i] == db[i]) begin
                    dc[i] <= '0;
                end else if (dc[i] == DB_LAST) begin
                    db[i] <= sync_b[i];
                    dc[i] <= '0;
                end else begin
                    dc[i] <= dc[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcnt      <= '0;
            moveLeft  <= 1'b0;
            moveRight <= 1'b0;
        end else begin
            moveLeft  <= 1'b0;
            moveRight <= 1'b0;
            if (frameTick) begin
                if (db[0] ^ db[1]) begin
                    if (mcnt == '0) begin
                        moveLeft  <= db[0];
                        moveRight <= db[1];
                        mcnt      <= MV_RELOAD;
                    end else begin
                        mcnt <= mcnt - CNT_ONE;
                    end
                end else begin
                    mcnt <= '0;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        ccnt_next  = ccnt;
        case (state)
            S_IDLE: begin
                if (frameTick && db[2] && armed && !laserBusy) state_next = S_REQ;
            end
            S_REQ: begin
                if (fireAck) state_next = S_FLIGHT;
            end
            S_FLIGHT: begin
                if (frameTick && !laserBusy) begin
                    if (FIRE_COOLDOWN_FRAMES == 0) begin
                        state_next = S_IDLE;
                    end else begin
                        ccnt_next  = CD_LOAD;
                        state_next = S_COOL;
                    end
                end
            end
            S_COOL: begin
                if (frameTick) begin
                    if (ccnt != '0) ccnt_next = ccnt - CNT_ONE;
                    if (ccnt <= CNT_ONE) state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // fireReq is registered from the next state so it tracks REQ without a decode stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            ccnt    <= '0;
            fireReq <= 1'b0;
            armed   <= 1'b1;
        end else begin
            state   <= state_next;
            ccnt    <= ccnt_next;
            fireReq <= (state_next == S_REQ);
            if (state != S_REQ && state_next == S_REQ) armed <= 1'b0;
            else if (!db[2])                           armed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ship_input_sequencer.sv
// Scoreboard bench: stimulus queues expected move pulses and fireReq rises tagged with
// the frame tick they must follow; a negedge monitor matches what the DUT produces.
module tb_ship_input_sequencer;

    logic clk = 1'b0;
    logic reset;
    logic frameTick = 1'b0;
    logic btnLeft, btnRight, btnFire, laserBusy, fireAck;
    logic moveLeft, moveRight, fireReq;

    localparam int K_LEFT  = 0;
    localparam int K_RIGHT = 1;
    localparam int K_FIRE  = 2;

    typedef struct {
        int kind;
        int tick;
    } ev_t;

    ev_t sbq[$];
    int  tests = 0;
    int  fails = 0;
    int  tick_count = 0;
    int  base;
    logic prev_ml = 1'b0, prev_mr = 1'b0, prev_req = 1'b0;

    ship_input_sequencer #(
        .FIRE_COOLDOWN_FRAMES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .frameTick(frameTick),
        .btnLeft  (btnLeft),
        .btnRight (btnRight),
        .btnFire  (btnFire),
        .laserBusy(laserBusy),
        .fireAck  (fireAck),
        .moveLeft (moveLeft),
        .moveRight(moveRight),
        .fireReq  (fireReq)
    );

    initial forever #5 clk = ~clk;

    // one-cycle frameTick every 8 clocks, changed on the falling edge
    initial begin
        forever begin
            repeat (7) @(negedge clk);
            frameTick = 1'b1;
            @(negedge clk);
            frameTick = 1'b0;
        end
    end

    always @(posedge clk) if (frameTick) tick_count <= tick_count + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic check_ev(input int kind);
        ev_t e;
        tests++;
        if (sbq.size() == 0) begin
            fails++;
            $display("FAIL sb_event: got kind=%0d tick=%0d, required no event", kind, tick_count);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.tick != tick_count) begin
                fails++;
                $display("FAIL sb_event: got kind=%0d tick=%0d, required kind=%0d tick=%0d",
                         kind, tick_count, e.kind, e.tick);
            end
        end
    endtask

    task automatic check_empty(input string name);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL %s: got %0d pending expected events, required 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic expect_ev(input int kind, input int tick);
        ev_t e;
        e.kind = kind;
        e.tick = tick;
        sbq.push_back(e);
    endtask

    task automatic wait_ticks(input int n);
        int target;
        target = tick_count + n;
        while (tick_count < target) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (moveLeft) begin
            tests++;
            if (moveRight || prev_ml) begin
                fails++;
                $display("FAIL move_left_shape: got right=%b prev=%b, required 0 0", moveRight, prev_ml);
            end
            check_ev(K_LEFT);
        end
        if (moveRight) begin
            tests++;
            if (prev_mr) begin
                fails++;
                $display("FAIL move_right_width: got prev=%b, required 0", prev_mr);
            end
            check_ev(K_RIGHT);
        end
        if (fireReq && !prev_req) check_ev(K_FIRE);
        prev_ml  = moveLeft;
        prev_mr  = moveRight;
        prev_req = fireReq;
    end

    initial begin
        logic any_high;
        reset = 1'b0;
        btnLeft = 1'b0; btnRight = 1'b0; btnFire = 1'b0;
        laserBusy = 1'b0; fireAck = 1'b0;
        #1;
        check("reset_fireReq", fireReq, 1'b0);
        check("reset_moveLeft", moveLeft, 1'b0);
        check("reset_moveRight", moveRight, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // 1: quiet for 10 frames, then asynchronous reset mid-cycle
        any_high = 1'b0;
        repeat (80) begin
            @(negedge clk);
            any_high = any_high | fireReq | moveLeft | moveRight;
        end
        check("idle_10_frames", any_high, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_fireReq", fireReq, 1'b0);
        check("async_rst_moves", moveLeft | moveRight, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        // 2: right held, pulses after ticks 3, 6, 9; released after 9
        wait_ticks(1);
        base = tick_count;
        btnRight = 1'b1;
        expect_ev(K_RIGHT, base + 3);
        expect_ev(K_RIGHT, base + 6);
        expect_ev(K_RIGHT, base + 9);
        wait_ticks(9);
        btnRight = 1'b0;
        wait_ticks(5);
        check_empty("right_hold_drain");

        // 3: both held, left released after tick 6, right pulses after 9 and 12
        wait_ticks(1);
        base = tick_count;
        btnLeft = 1'b1; btnRight = 1'b1;
        expect_ev(K_RIGHT, base + 9);
        expect_ev(K_RIGHT, base + 12);
        wait_ticks(6);
        btnLeft = 1'b0;
        wait_ticks(6);
        btnRight = 1'b0;
        wait_ticks(4);
        check_empty("both_then_right_drain");

        // 4: single shot, ack 5 cycles in, no repeat while held
        wait_ticks(1);
        base = tick_count;
        btnFire = 1'b1;
        expect_ev(K_FIRE, base + 3);
        wait_ticks(3);
        repeat (5) @(negedge clk);
        check("req_held_until_ack", fireReq, 1'b1);
        fireAck = 1'b1;
        @(negedge clk);
        fireAck = 1'b0;
        check("req_fall_after_ack", fireReq, 1'b0);
        wait_ticks(50);
        check_empty("fire_hold_no_repeat");
        check("fire_hold_req_low", fireReq, 1'b0);
        btnFire = 1'b0;
        wait_ticks(3);

        // 5: busy 3 frames after ack, COOL at tick 7, next request after tick 12
        wait_ticks(1);
        base = tick_count;
        btnFire = 1'b1;
        expect_ev(K_FIRE, base + 3);
        expect_ev(K_FIRE, base + 12);
        wait_ticks(3);
        fireAck = 1'b1;
        laserBusy = 1'b1;
        @(negedge clk);
        fireAck = 1'b0;
        check("cool_req_fall", fireReq, 1'b0);
        btnFire = 1'b0;
        wait_ticks(3);
        laserBusy = 1'b0;
        btnFire = 1'b1;
        wait_ticks(6);
        fireAck = 1'b1;
        @(negedge clk);
        fireAck = 1'b0;
        check("cool_second_fall", fireReq, 1'b0);
        btnFire = 1'b0;
        wait_ticks(8);
        check_empty("cooldown_drain");
        laserBusy = 1'b1;
        btnFire = 1'b1;
        wait_ticks(8);
        check_empty("busy_idle_no_req");
        check("busy_idle_req_low", fireReq, 1'b0);
        btnFire = 1'b0;
        wait_ticks(3);
        laserBusy = 1'b0;
        wait_ticks(1);

        // 6: reset during REQ, then full debounce before the fresh request
        wait_ticks(1);
        base = tick_count;
        btnFire = 1'b1;
        expect_ev(K_FIRE, base + 3);
        wait_ticks(3);
        check("req_before_reset", fireReq, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("req_async_reset", fireReq, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        expect_ev(K_FIRE, base + 6);
        wait_ticks(3);
        fireAck = 1'b1;
        @(negedge clk);
        fireAck = 1'b0;
        check("post_reset_fall", fireReq, 1'b0);
        btnFire = 1'b0;
        wait_ticks(3);
        check_empty("post_reset_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
